adc_ltc2308_scan: RTL and testbench

Parametrised multi-channel scan controller for the LTC2308 SPI ADC. Replaces the single-shot, single-channel capture block with automatic round-robin scanning over a channel mask, single-pass and continuous modes, and a tagged valid/ready result stream. It handles the LTC2308 one-frame pipeline internally: each frame's SDI word selects the next conversion, and its SDO word returns the previous one. It sits between the ADC pins and the capture/transfer logic that feeds the host bridge.

---
 rtl/adc_ltc2308_scan_if.sv | 10 +
 rtl/adc_ltc2308_scan.sv | 206 ++++++++++++++++++++
 tb/tb_adc_ltc2308_scan.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ltc2308_scan_if.sv
// Tagged result stream from the LTC2308 scan controller to its consumer.
interface adc_ltc2308_scan_if;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [2:0]  out_channel;

  modport master (output out_valid, output out_data, output out_channel, input out_ready);
  modport slave  (input out_valid, input out_data, input out_channel, output out_ready);
endinterface

// File: rtl/adc_ltc2308_scan.sv
// Round-robin LTC2308 scan controller: CONVST/SCK/SDI sequencing, SDO capture and a
// one-deep tagged result register, with the one-frame config/data pipeline hidden inside.
module adc_ltc2308_scan #(
  parameter int unsigned NUM_CH      = 8,
  parameter bit          UNIPOLAR    = 1'b1,
  parameter int unsigned CONVST_HIGH = 2,
  parameter int unsigned CONV_CYCLES = 64,
  parameter int unsigned SCK_HALF    = 1,
  parameter int unsigned ACQ_CYCLES  = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                cont,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  adc_ltc2308_scan_if.master  res,
  output logic                CONVST,
  output logic                SCK,
  output logic                SDI,
  input  logic                SDO
);

  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MAX_A  = (CONV_CYCLES > ACQ_CYCLES) ? CONV_CYCLES : ACQ_CYCLES;
  localparam int unsigned MAX_C  = (MAX_A > SCK_HALF) ? MAX_A : SCK_HALF;
  localparam int unsigned CNT_W  = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, ACQ} state_t;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--)
      if (m[IDX_W'(i)]) r = CH_W'(i);
    return r;
  endfunction

  function automatic logic [CH_W-1:0] highest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_CH); i++)
      if (m[IDX_W'(i)]) r = CH_W'(i);
    return r;
  endfunction

  // Next enabled channel above cur, wrapping to the lowest enabled one.
  function automatic logic [CH_W-1:0] next_ch(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] cur);
    logic [CH_W-1:0] r;
    r = lowest_ch(m);
    for (int i = int'(NUM_CH) - 1; i >= 0; i--)
      if (m[IDX_W'(i)] && (CH_W'(i) > cur)) r = CH_W'(i);
    return r;
  endfunction

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          bit_cnt;
  logic [5:0]          cfg_sr;
  logic [DATA_W-2:0]   shreg;
  logic [NUM_CH-1:0]   mask_q;
  logic [CH_W-1:0]     send_ch;
  logic [CH_W-1:0]     ret_ch;
  logic                prime;
  logic                cont_mode;
  logic                stop_q;

  logic [5:0]          cfg_c;
  logic [DATA_W-1:0]   sample_c;
  logic                keep_going_c;
  logic                load_c;
  logic                clear_ovr_c;

  // S/D, O/S, S1, S0, UNI, SLP
  assign cfg_c        = {1'b1, send_ch[0], send_ch[2], send_ch[1], UNIPOLAR, 1'b0};
  assign sample_c     = {shreg, SDO};
  assign keep_going_c = cont_mode ? (cont && !stop_q)
                                  : !(!prime && (ret_ch == highest_ch(mask_q)));
  assign load_c       = (state == SHIFT) && !SCK && (cnt == CNT_W'(SCK_HALF - 1)) &&
                        (bit_cnt == 4'd11) && !prime;
  assign clear_ovr_c  = (state == IDLE) && start && (|ch_mask);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      cfg_sr    <= '0;
      shreg     <= '0;
      mask_q    <= '0;
      send_ch   <= '0;
      ret_ch    <= '0;
      prime     <= 1'b0;
      cont_mode <= 1'b0;
      stop_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      CONVST    <= 1'b0;
      SCK       <= 1'b0;
      SDI       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start || cont) begin
            if (|ch_mask) begin
              state     <= CONV;
              busy      <= 1'b1;
              CONVST    <= 1'b1;
              cnt       <= '0;
              mask_q    <= ch_mask;
              send_ch   <= lowest_ch(ch_mask);
              prime     <= 1'b1;
              cont_mode <= cont;
              stop_q    <= 1'b0;
            end else if (start) begin
              done <= 1'b1;
            end
          end
        end
        CONV: begin
          if (cnt == CNT_W'(CONVST_HIGH - 1)) CONVST <= 1'b0;
          if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
            state   <= SHIFT;
            cnt     <= '0;
            bit_cnt <= '0;
            SDI     <= cfg_c[5];
            cfg_sr  <= {cfg_c[4:0], 1'b0};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          // SDO is captured on the edge that raises SCK; SDI moves only as SCK falls.
          if (cnt == CNT_W'(SCK_HALF - 1)) begin
            cnt <= '0;
            if (!SCK) begin
              SCK   <= 1'b1;
              shreg <= sample_c[DATA_W-2:0];
            end else begin
              SCK <= 1'b0;
              if (bit_cnt == 4'd11) begin
                state <= ACQ;
                SDI   <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                SDI     <= cfg_sr[5];
                cfg_sr  <= {cfg_sr[4:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACQ: begin
          if (cont_mode && !cont) stop_q <= 1'b1;
          if (cnt == CNT_W'(ACQ_CYCLES - 1)) begin
            cnt <= '0;
            if (keep_going_c) begin
              state   <= CONV;
              CONVST  <= 1'b1;
              prime   <= 1'b0;
              ret_ch  <= send_ch;
              send_ch <= next_ch(mask_q, send_ch);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-deep result register; a result arriving while the old one is unaccepted is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      res.out_valid   <= 1'b0;
      res.out_data    <= '0;
      res.out_channel <= '0;
      overrun         <= 1'b0;
    end else begin
      if (load_c) begin
        if (!res.out_valid || res.out_ready) begin
          res.out_valid   <= 1'b1;
          res.out_data    <= sample_c;
          res.out_channel <= ret_ch;
        end else begin
          overrun <= 1'b1;
        end
      end else if (res.out_ready) begin
        res.out_valid <= 1'b0;
      end
      if (clear_ovr_c) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_ltc2308_scan.sv
// Directed bench for adc_ltc2308_scan: an SDO word per frame, SDI/result/done monitors,
// and hand-computed expectations checked with immediate assertions.
module tb_adc_ltc2308_scan;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cont  = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic       busy, done, overrun, CONVST, SCK, SDI;
  logic       SDO = 1'b0;

  adc_ltc2308_scan_if res_if ();

  adc_ltc2308_scan dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .cont    (cont),
    .ch_mask (ch_mask),
    .busy    (busy),
    .done    (done),
    .overrun (overrun),
    .res     (res_if),
    .CONVST  (CONVST),
    .SCK     (SCK),
    .SDI     (SDI),
    .SDO     (SDO)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] sdo_word [0:63];
  logic [5:0]  sdi_log  [0:63];
  logic [14:0] res_log  [0:63];
  int   conv_rises = 0;
  int   sck_idx    = 0;
  int   res_cnt    = 0;
  int   done_cnt   = 0;
  int   done_bad   = 0;
  logic convst_q = 1'b0, sck_q = 1'b0, busy_q = 1'b0;

  function automatic logic [5:0] slot(input int k);
    return 6'(k);
  endfunction

  // ADC model and bus monitor, sampled just after each rising edge.
  always @(posedge clock) begin
    logic [11:0] w;
    #1;
    if (CONVST && !convst_q) begin
      conv_rises++;
      sck_idx = 0;
      w = sdo_word[slot(conv_rises - 1)];
      SDO = w[11];
    end
    if (SCK && !sck_q) begin
      if (sck_idx < 6) sdi_log[slot(conv_rises - 1)][3'(5 - sck_idx)] = SDI;
      sck_idx++;
      w = sdo_word[slot(conv_rises - 1)];
      if (sck_idx < 12) SDO = w[4'(11 - sck_idx)];
    end
    if (res_if.out_valid && res_if.out_ready) begin
      res_log[slot(res_cnt)] = {res_if.out_channel, res_if.out_data};
      res_cnt++;
    end
    if (done) done_cnt++;
    if (busy_q && !busy && !done && !reset) done_bad++;
    convst_q = CONVST;
    sck_q    = SCK;
    busy_q   = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(negedge clock);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  int f0, r0, d0, n;

  initial begin
    for (int i = 0; i < 64; i++) sdo_word[i] = 12'h000;
    res_if.out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_outputs", 32'({busy, done, overrun, CONVST, SCK, SDI, res_if.out_valid}), 32'd0);
    check("rst_data", 32'({res_if.out_channel, res_if.out_data}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single channel 0, single pass
    f0 = conv_rises; r0 = res_cnt; d0 = done_cnt;
    sdo_word[slot(f0)]     = 12'hABC;
    sdo_word[slot(f0 + 1)] = 12'h801;
    pulse_start(8'h01);
    check("t1_busy_convst", 32'({busy, CONVST}), 32'd3);
    n = 0;
    while (!res_if.out_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("t1_latency", 32'(n), 32'd185);
    wait_idle("t1");
    check("t1_results", 32'(res_cnt - r0), 32'd1);
    check("t1_data", 32'(res_log[slot(r0)]), 32'({3'd0, 12'h801}));
    check("t1_frames", 32'(conv_rises - f0), 32'd2);
    check("t1_sdi0", 32'(sdi_log[slot(f0)]), 32'(6'b100010));
    check("t1_done", 32'(done_cnt - d0), 32'd1);

    // Mask 0x26, with a start pulse mid-pass that must be ignored
    f0 = conv_rises; r0 = res_cnt; d0 = done_cnt;
    sdo_word[slot(f0)]     = 12'h000;
    sdo_word[slot(f0 + 1)] = 12'h123;
    sdo_word[slot(f0 + 2)] = 12'h456;
    sdo_word[slot(f0 + 3)] = 12'h789;
    pulse_start(8'h26);
    repeat (150) @(negedge clock);
    ch_mask = 8'h01;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    ch_mask = 8'h26;
    wait_idle("t2");
    check("t2_results", 32'(res_cnt - r0), 32'd3);
    check("t2_res0", 32'(res_log[slot(r0)]),     32'({3'd1, 12'h123}));
    check("t2_res1", 32'(res_log[slot(r0 + 1)]), 32'({3'd2, 12'h456}));
    check("t2_res2", 32'(res_log[slot(r0 + 2)]), 32'({3'd5, 12'h789}));
    check("t2_frames", 32'(conv_rises - f0), 32'd4);
    check("t2_sdi0", 32'(sdi_log[slot(f0)]),     32'(6'b110010));
    check("t2_sdi1", 32'(sdi_log[slot(f0 + 1)]), 32'(6'b100110));
    check("t2_sdi2", 32'(sdi_log[slot(f0 + 2)]), 32'(6'b111010));
    check("t2_sdi3", 32'(sdi_log[slot(f0 + 3)]), 32'(6'b110010));
    check("t2_done", 32'(done_cnt - d0), 32'd1);

    // Continuous on channel 7 for three frames
    f0 = conv_rises; r0 = res_cnt; d0 = done_cnt;
    for (int k = 0; k < 4; k++) sdo_word[slot(f0 + k)] = 12'hFFF;
    @(negedge clock);
    ch_mask = 8'h80;
    cont    = 1'b1;
    n = 0;
    while ((conv_rises - f0) < 3 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    cont = 1'b0;
    check("t3_third_frame", 32'(conv_rises - f0), 32'd3);
    wait_idle("t3");
    check("t3_results", 32'(res_cnt - r0), 32'd2);
    check("t3_res0", 32'(res_log[slot(r0)]),     32'({3'd7, 12'hFFF}));
    check("t3_res1", 32'(res_log[slot(r0 + 1)]), 32'({3'd7, 12'hFFF}));
    check("t3_frames", 32'(conv_rises - f0), 32'd3);
    check("t3_sdi0", 32'(sdi_log[slot(f0)]), 32'(6'b111110));
    check("t3_done", 32'(done_cnt - d0), 32'd1);

    // Consumer stalled across two results
    f0 = conv_rises;
    res_if.out_ready = 1'b0;
    sdo_word[slot(f0 + 1)] = 12'h111;
    sdo_word[slot(f0 + 2)] = 12'h222;
    pulse_start(8'h03);
    wait_idle("t4");
    check("t4_valid", 32'(res_if.out_valid), 32'd1);
    check("t4_kept", 32'({res_if.out_channel, res_if.out_data}), 32'({3'd0, 12'h111}));
    check("t4_overrun", 32'(overrun), 32'd1);
    @(negedge clock);
    res_if.out_ready = 1'b1;
    @(negedge clock);
    check("t4_drained", 32'({res_if.out_valid, overrun}), 32'd1);

    // Accepted start clears overrun; then reset in the middle of SHIFT
    pulse_start(8'h01);
    check("t5_ovr_clear", 32'(overrun), 32'd0);
    n = 0;
    while (!SCK && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("t5_in_shift", 32'({SCK, SDI}), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    check("t5_reset", 32'({CONVST, SCK, SDI, res_if.out_valid, busy, done}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    f0 = conv_rises; r0 = res_cnt;
    sdo_word[slot(f0)]     = 12'hBAD;
    sdo_word[slot(f0 + 1)] = 12'h5A5;
    pulse_start(8'h04);
    check("t5_restart", 32'({busy, CONVST}), 32'd3);
    wait_idle("t5");
    check("t5_results", 32'(res_cnt - r0), 32'd1);
    check("t5_data", 32'(res_log[slot(r0)]), 32'({3'd2, 12'h5A5}));
    check("t5_frames", 32'(conv_rises - f0), 32'd2);
    check("t5_sdi0", 32'(sdi_log[slot(f0)]), 32'(6'b100110));

    // Start with an empty mask
    f0 = conv_rises; d0 = done_cnt;
    pulse_start(8'h00);
    check("t6_done_pulse", 32'({done, busy, CONVST}), 32'd4);
    @(negedge clock);
    check("t6_done_low", 32'(done), 32'd0);
    repeat (5) @(negedge clock);
    check("t6_no_convst", 32'(conv_rises - f0), 32'd0);
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd1);

    check("done_at_busy_fall", 32'(done_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
